// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types, constants and header helper for the router packet transmitter
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    PLD,
    PAR,
    GAP
  } tx_state_e;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int         MAX_LEN      = 63;
  localparam int         LEN_W        = $clog2(MAX_LEN + 1);

  function automatic logic [7:0] hdr_byte(input logic [1:0] addr, input logic [LEN_W-1:0] len);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - command, payload and router-side signals of router_pkt_tx
// ROUTER_TX_PARITY_ERR_INJ_EN adds cmd_inj_err.
interface router_pkt_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
  logic       cmd_inj_err;
`endif
  logic       pld_valid;
  logic       pld_ready;
  logic [7:0] pld_data;
  logic       busy;
  logic [7:0] data_in;
  logic       pkt_valid;

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_inj_err, pld_valid, pld_data, busy,
    output cmd_ready, pld_ready, data_in, pkt_valid
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_inj_err, pld_valid, pld_data, busy,
    input  cmd_ready, pld_ready, data_in, pkt_valid
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, pld_valid, pld_data, busy,
    output cmd_ready, pld_ready, data_in, pkt_valid
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, pld_valid, pld_data, busy,
    input  cmd_ready, pld_ready, data_in, pkt_valid
  );
`endif

endinterface

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - 8-bit payload buffer with independent write/read pointers and registered read
module router_tx_buf #(
  parameter int DEPTH = 64
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data
);

  logic [7:0] mem [DEPTH];
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers restart at every packet, so a packet never wraps the buffer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 6'd1;
      if (rd_en) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 6'd1;
      end
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - store-and-forward packet transmitter for the router input port
// ROUTER_TX_PARITY_ERR_INJ_EN adds cmd_inj_err, which flips bit 0 of the sent parity.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IFG_CYCLES = 1,
  parameter int BUF_DEPTH  = 64
) (
  input  logic            clock,
  input  logic            resetn,
  router_pkt_tx_if.master bus,
  output logic            cmd_err,
  output logic            pkt_done,
  output logic            tx_active
);

  localparam int GAP_W = 16;

  tx_state_e        state;
  logic [1:0]       addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] rcnt;
  logic [7:0]       data_q;
  logic [7:0]       parity;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       buf_rd_data;
  logic [7:0]       par_flip;
  logic             cmd_ok;
  logic             cmd_fire;
  logic             accept;
  logic             wr_en;
  logic             rd_en;

  assign cmd_ok   = (bus.cmd_addr != ADDR_INVALID) && (bus.cmd_len != '0);
  assign cmd_fire = (state == IDLE) && bus.cmd_valid && bus.cmd_ready && cmd_ok;
  assign accept   = !bus.busy;
  assign wr_en    = (state == LOAD) && bus.pld_valid && bus.pld_ready;
  // Fetch byte 0 on header acceptance, then one byte ahead per accepted payload byte.
  assign rd_en    = accept && ((state == HDR) ||
                               ((state == PLD) && (rcnt != len_q - LEN_W'(1))));

  assign bus.data_in = (state == PLD) ? buf_rd_data : data_q;

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
  logic inj_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       inj_q <= 1'b0;
    else if (cmd_fire) inj_q <= bus.cmd_inj_err;
  end

  assign par_flip = {7'd0, inj_q};
`else
  assign par_flip = 8'h00;
`endif

  router_tx_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clock   (clock),
    .resetn  (resetn),
    .clr     (cmd_fire),
    .wr_en   (wr_en),
    .wr_data (bus.pld_data),
    .rd_en   (rd_en),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.pld_ready <= 1'b0;
      bus.pkt_valid <= 1'b0;
      data_q        <= '0;
      cmd_err       <= 1'b0;
      pkt_done      <= 1'b0;
      tx_active     <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt           <= '0;
      rcnt          <= '0;
      parity        <= '0;
      gap_cnt       <= '0;
    end else begin
      cmd_err  <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            if (!cmd_ok) begin
              cmd_err <= 1'b1;
            end else begin
              addr_q        <= bus.cmd_addr;
              len_q         <= bus.cmd_len;
              cnt           <= '0;
              rcnt          <= '0;
              parity        <= '0;
              bus.cmd_ready <= 1'b0;
              bus.pld_ready <= 1'b1;
              tx_active     <= 1'b1;
              state         <= LOAD;
            end
          end
        end
        LOAD: begin
          if (wr_en) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              bus.pld_ready <= 1'b0;
              bus.pkt_valid <= 1'b1;
              data_q        <= hdr_byte(addr_q, len_q);
              state         <= HDR;
            end
          end
        end
        HDR: begin
          if (accept) begin
            parity <= parity ^ data_q;
            state  <= PLD;
          end
        end
        PLD: begin
          if (accept) begin
            parity <= parity ^ buf_rd_data;
            if (rcnt == len_q - LEN_W'(1)) begin
              bus.pkt_valid <= 1'b0;
              data_q        <= parity ^ buf_rd_data ^ par_flip;
              state         <= PAR;
            end else begin
              rcnt <= rcnt + LEN_W'(1);
            end
          end
        end
        PAR: begin
          if (accept) begin
            pkt_done <= 1'b1;
            data_q   <= '0;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_W'(IFG_CYCLES)) begin
            if (!bus.busy) begin
              bus.cmd_ready <= 1'b1;
              tx_active     <= 1'b0;
              state         <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - scoreboard bench for router_pkt_tx with a byte-level reference model
module tb_router_pkt_tx;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic cmd_err;
  logic pkt_done;
  logic tx_active;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.IFG_CYCLES(1), .BUF_DEPTH(64)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .cmd_err   (cmd_err),
    .pkt_done  (pkt_done),
    .tx_active (tx_active)
  );

  int         n_cmp    = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         n_pkts   = 0;
  bit         in_pkt   = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] pld_q[$];

  initial forever #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: header, payload with pkt_valid high, then XOR of all of them with pkt_valid low.
  task automatic expect_pkt(input logic [1:0] a, input logic [5:0] l, input bit inj);
    logic [7:0] hdr;
    logic [7:0] par;
    hdr = {l, a};
    par = hdr;
    exp_q.push_back({1'b1, hdr});
    foreach (pld_q[i]) begin
      exp_q.push_back({1'b1, pld_q[i]});
      par ^= pld_q[i];
    end
    if (inj) par ^= 8'h01;
    exp_q.push_back({1'b0, par});
  endtask

  task automatic fill_random(input int len);
    pld_q.delete();
    for (int k = 0; k < len; k++) pld_q.push_back(8'($urandom));
  endtask

  task automatic monitor();
    logic [8:0] e;
    logic [7:0] prev_d      = '0;
    logic       prev_busy   = 1'b0;
    logic       prev_pv     = 1'b0;
    logic       prev_inpkt  = 1'b0;
    logic       exp_done    = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        exp_q.delete();
        in_pkt    = 1'b0;
        prev_busy = 1'b0;
        exp_done  = 1'b0;
      end else begin
        if (prev_busy && (prev_pv || prev_inpkt)) begin
          check("hold_data", bus.data_in, prev_d);
          check("hold_valid", bus.pkt_valid, prev_pv);
        end
        if (exp_done || pkt_done) check("pkt_done", pkt_done, exp_done);
        if (pkt_done) done_cnt++;
        exp_done   = 1'b0;
        prev_busy  = bus.busy;
        prev_pv    = bus.pkt_valid;
        prev_d     = bus.data_in;
        prev_inpkt = in_pkt;
        if (!bus.busy && (bus.pkt_valid || in_pkt)) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h valid %0b with no byte expected at %0t",
                     bus.data_in, bus.pkt_valid, $time);
          end else begin
            e = exp_q.pop_front();
            check("byte", {bus.pkt_valid, bus.data_in}, e);
          end
          if (bus.pkt_valid) in_pkt = 1'b1;
          else begin
            in_pkt   = 1'b0;
            exp_done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input bit inj);
    int i = 0;
    int n = 0;
    bit wr;
    while (!bus.cmd_ready && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    expect_pkt(a, l, inj);
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    bus.cmd_inj_err = inj;
`endif
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    check("tx_active_load", tx_active, 1);
    n = 0;
    while (i < int'(l) && n < 2000) begin
      bus.pld_valid = ($urandom_range(0, 3) != 0);
      bus.pld_data  = pld_q[i];
      wr = bus.pld_valid && bus.pld_ready;
      @(posedge clock); #1;
      if (wr) i++;
      n++;
    end
    bus.pld_valid = 1'b0;
    check("payload_written", i, int'(l));
  endtask

  // Runs the router side until pkt_done; optionally random busy and stray commands.
  task automatic drain(input bit rnd, input bit poke);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 3000) begin
      @(posedge clock); #1;
      bus.busy = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (poke) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 2'($urandom_range(0, 2));
        bus.cmd_len   = 6'($urandom_range(1, 63));
      end
      n++;
    end
    bus.busy      = 1'b0;
    bus.cmd_valid = 1'b0;
    check("pkt_done_seen", done_cnt - start, 1);
    check("queue_empty", exp_q.size(), 0);
    n_pkts++;
  endtask

  task automatic reject(input logic [1:0] a, input logic [5:0] l);
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    bus.pld_valid = 1'b1;
    @(posedge clock); #1;
    check("cmd_err_pulse", cmd_err, 1);
    check("rej_tx_active", tx_active, 0);
    check("rej_pld_ready", bus.pld_ready, 0);
    bus.cmd_valid = 1'b0;
    @(posedge clock); #1;
    check("cmd_err_clear", cmd_err, 0);
    check("rej_tx_active2", tx_active, 0);
    check("rej_pld_ready2", bus.pld_ready, 0);
    bus.pld_valid = 1'b0;
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.pld_valid = 1'b0;
    bus.pld_data  = '0;
    bus.busy      = 1'b0;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    bus.cmd_inj_err = 1'b0;
`endif
    fork
      monitor();
    join_none

    #12;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_pkt_valid", bus.pkt_valid, 0);
    check("rst_data_in", bus.data_in, 0);
    check("rst_pld_ready", bus.pld_ready, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_tx_active", tx_active, 0);
    @(posedge clock); #1;
    resetn = 1'b1;

    pld_q = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd1, 6'd3, 1'b0);
    drain(1'b0, 1'b0);

    // Busy for 3 cycles after the header, then 2 cycles mid-payload.
    fill_random(5);
    send_pkt(2'd2, 6'd5, 1'b0);
    @(posedge clock); #1;
    bus.busy = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    bus.busy = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    bus.busy = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    bus.busy = 1'b0;
    drain(1'b0, 1'b0);

    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(posedge clock); #1; n++; end
    reject(2'd3, 6'd5);
    reject(2'd0, 6'd0);

    pld_q.delete();
    for (int k = 0; k < 63; k++) pld_q.push_back(8'(k + 1));
    send_pkt(2'd0, 6'd63, 1'b0);
    drain(1'b1, 1'b1);

    pld_q = '{8'hA5};
    send_pkt(2'd0, 6'd1, 1'b0);
    drain(1'b1, 1'b0);

    // Reset asserted between clock edges while payload is streaming.
    fill_random(20);
    send_pkt(2'd1, 6'd20, 1'b0);
    n = 0;
    while (exp_q.size() > 14 && n < 500) begin @(posedge clock); #1; n++; end
    #2;
    resetn = 1'b0;
    #1;
    check("arst_pkt_valid", bus.pkt_valid, 0);
    check("arst_data_in", bus.data_in, 0);
    check("arst_tx_active", tx_active, 0);
    check("arst_cmd_ready", bus.cmd_ready, 1);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clock); #1;
    fill_random(4);
    send_pkt(2'd2, 6'd4, 1'b0);
    drain(1'b0, 1'b0);

    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(1, 63);
      fill_random(len);
      send_pkt(2'($urandom_range(0, 2)), 6'(len), 1'b0);
      drain(1'b1, 1'b1);
    end

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    fill_random(2);
    send_pkt(2'd2, 6'd2, 1'b1);
    drain(1'b0, 1'b0);
`endif

    repeat (5) @(posedge clock);
    check("total_pkt_done", done_cnt, n_pkts);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
